// File: rtl/reg_file_3p.sv
// 32-entry, two-read/one-write register file for the single-cycle MIPS core.
// Storage has no per-entry reset; a post-reset sweep clears it and then raises ready.
module reg_file_3p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic              we3,
  input  logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] dbg_a,
  output logic [DATA_W-1:0] dbg_rd,
  output logic              ready
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_idx;

  logic [DATA_W-1:0] mem [NREG];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Register zero is hard-wired; CLEAR hides contents that may still be stale.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              run,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] word
  );
    if (!run || addr == '0) return '0;
    return word;
  endfunction

  // Control: sweep index and run/clear state
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= ADDR_W'(1);
      ready   <= 1'b0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == LAST_IDX) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end
  end

  // Single write port shared by the sweep and the core, so the array stays LUTRAM-shaped.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_idx;
    wr_data = '0;
    if (!reset) begin
      if (state == CLEAR) begin
        wr_en = 1'b1;
      end else if (we3 && a3 != '0) begin
        wr_en   = 1'b1;
        wr_addr = a3;
        wr_data = wd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Reads are asynchronous with no write bypass; wd3 depends on rd1/rd2 via the ALU.
  assign rd1    = read_port(state == RUN, a1, mem[a1]);
  assign rd2    = read_port(state == RUN, a2, mem[a2]);
  assign dbg_rd = read_port(state == RUN, dbg_a, mem[dbg_a]);

endmodule

// File: tb/tb_reg_file_3p.sv
// Directed bench for reg_file_3p: reset sweep, writes, register zero and reset recovery.
module tb_reg_file_3p;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  a1, a2, a3, dbg_a;
  logic        we3;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2, dbg_rd;
  logic        ready;

  int checks = 0;
  int errors = 0;

  reg_file_3p #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .a1     (a1),
    .a2     (a2),
    .a3     (a3),
    .we3    (we3),
    .wd3    (wd3),
    .rd1    (rd1),
    .rd2    (rd2),
    .dbg_a  (dbg_a),
    .dbg_rd (dbg_rd),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until ready rises, bounded at 40.
  task automatic wait_ready(output int edges);
    edges = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (ready === 1'b1) begin
        edges = n;
        break;
      end
    end
  endtask

  initial begin
    int edges;
    reset = 1'b1; we3 = 1'b0; wd3 = '0;
    a1 = '0; a2 = '0; a3 = '0; dbg_a = '0;

    // Reset for two cycles, with a write held on throughout reset and the sweep.
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'h1234_5678; a1 = 5'd5;
    step();
    step();
    check("reset_ready", {31'b0, ready}, 32'h0);
    check("reset_rd1", rd1, 32'h0);
    reset = 1'b0;

    step();
    step();
    check("sweep_ready_low", {31'b0, ready}, 32'h0);
    check("sweep_rd1_forced0", rd1, 32'h0);
    wait_ready(edges);
    we3 = 1'b0;
    check("sweep_edges", edges + 2, 31);

    for (int i = 0; i < 32; i++) begin
      dbg_a = 5'(i);
      #1;
      check($sformatf("clear_reg%0d", i), dbg_rd, 32'h0);
    end
    a1 = 5'd5;
    #1;
    check("clear_blocked_reg5", rd1, 32'h0);

    // Write then read, with no same-cycle bypass.
    a3 = 5'd8; wd3 = 32'hDEAD_BEEF; we3 = 1'b1; a1 = 5'd8;
    #1;
    check("no_bypass_rd1", rd1, 32'h0);
    step();
    we3 = 1'b0; a2 = 5'd8; dbg_a = 5'd8;
    #1;
    check("wr8_rd1", rd1, 32'hDEAD_BEEF);
    check("wr8_rd2", rd2, 32'hDEAD_BEEF);
    check("wr8_dbg", dbg_rd, 32'hDEAD_BEEF);

    // Register zero discards writes.
    a3 = 5'd0; wd3 = 32'hFFFF_FFFF; we3 = 1'b1;
    step();
    we3 = 1'b0; a1 = 5'd0; dbg_a = 5'd0;
    #1;
    check("reg0_rd1", rd1, 32'h0);
    check("reg0_dbg", dbg_rd, 32'h0);

    // Back-to-back writes.
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'd1;
    step();
    a3 = 5'd4; wd3 = 32'd2;
    step();
    a3 = 5'd3; wd3 = 32'd7;
    step();
    we3 = 1'b0; a1 = 5'd3; a2 = 5'd4;
    #1;
    check("b2b_rd1", rd1, 32'd7);
    check("b2b_rd2", rd2, 32'd2);

    // Reset during operation, then again at edge 10 of the fresh sweep.
    a3 = 5'd31; wd3 = 32'hA5A5_A5A5; we3 = 1'b1;
    step();
    we3 = 1'b0; dbg_a = 5'd31;
    #1;
    check("reg31_written", dbg_rd, 32'hA5A5_A5A5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 0; n < 9; n++) step();
    check("mid_sweep_ready", {31'b0, ready}, 32'h0);
    check("mid_sweep_dbg_forced0", dbg_rd, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_ready(edges);
    check("resweep_edges", edges, 31);
    check("resweep_reg31", dbg_rd, 32'h0);
    a1 = 5'd8; a2 = 5'd3;
    #1;
    check("resweep_reg8", rd1, 32'h0);
    check("resweep_reg3", rd2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_3p.md
Name: reg_file_3p

Overview:
- 32-entry general-purpose register file directly downstream of the single-cycle MIPS core.
- Consumes the core's register_a1/a2/a3, register_we3 and register_wd3 outputs and returns register_rd1/rd2.
- Storage is a single-write-port array, so it maps to LUTRAM. Reset therefore clears the array with a sequential sweep rather than per-flop resets.
- Adds a debug read port for the testbench and a ready flag that gates core start-up.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; NREG = 2**ADDR_W entries

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset; starts the clear sweep
a1  input  ADDR_W  read port 1 address (rs)
a2  input  ADDR_W  read port 2 address (rt)
a3  input  ADDR_W  write address (rt/rd)
we3  input  1  write enable for port 3
wd3  input  DATA_W  write data
rd1  output  DATA_W  read data, port 1
rd2  output  DATA_W  read data, port 2
dbg_a  input  ADDR_W  debug read address
dbg_rd  output  DATA_W  debug read data
ready  output  1  high when the sweep is complete and the file accepts writes

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- State machine: two states, CLEAR and RUN. The only other sequential state is a clear index clr_idx of width ADDR_W.
- Reset (sampled high at a clk edge):
  - state <= CLEAR, clr_idx <= 1, ready <= 0.
  - No array write occurs in that cycle.
  - Reset asserted at any time, including mid-sweep or mid-program, restarts the sweep from index 1.
- CLEAR, reset low, each edge:
  - mem[clr_idx] <= 0 and clr_idx <= clr_idx + 1.
  - When the write is to index NREG-1: state <= RUN and ready <= 1. clr_idx wraps to 0 and is unused in RUN.
  - ready therefore rises on the 31st edge after reset deasserts (NREG-1 edges).
  - we3 is ignored throughout CLEAR.
- RUN, each edge:
  - If we3 = 1 and a3 != 0: mem[a3] <= wd3.
  - Writes to a3 = 0 are discarded.
- Reads:
  - rd1, rd2 and dbg_rd are combinational (asynchronous) with zero latency. The single-cycle core needs operands in the same cycle.
  - Address 0 always reads 0, independent of array contents.
  - In CLEAR, rd1, rd2 and dbg_rd are forced to 0, so stale or X contents never leave the block.
- No write-to-read bypass:
  - A read of the register being written in the same cycle returns the old value; the new value is visible after the edge.
  - Bypass is forbidden. The core's wd3 depends combinationally on rd1/rd2 through the ALU, so a bypass would create a combinational loop.
- Simultaneous events:
  - reset together with we3: reset wins and no write occurs.
  - a1 == a2: both ports return the same value.
- Outputs after reset: ready = 0, rd1/rd2/dbg_rd = 0 until the sweep completes. No other outputs.
- Width: wd3 is stored unmodified with no sign or zero manipulation. Addresses are used as-is; NREG covers every address value, so there is no out-of-range case.

Test Plan:
- Reset sweep: assert reset for 2 cycles, then release. Required: ready = 0 for exactly 31 edges, then 1. Read all 32 regs via dbg_a: every value = 0x00000000.
- Write then read: write a3=8, wd3=0xDEADBEEF, we3=1. In the same cycle a1=8 must read 0. After the edge, rd1 = rd2 = dbg_rd = 0xDEADBEEF with a1=a2=dbg_a=8.
- Register zero: write a3=0, wd3=0xFFFFFFFF, we3=1. Afterwards rd1 with a1=0 must read 0x00000000.
- Writes blocked during CLEAR: assert we3=1, a3=5, wd3=0x12345678 throughout the sweep. After ready=1, reg 5 must read 0.
- Reset mid-operation: write reg 31 = 0xA5A5A5A5 and confirm it. Reset for 1 cycle at edge 10 of a fresh sweep. Required: ready low for 31 edges after release, and reg 31 = 0.
- Back-to-back writes: write reg 3 = 1, reg 4 = 2, reg 3 = 7 on consecutive edges. Required: rd1 = 7 (a1=3) and rd2 = 2 (a2=4).
